pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Instruction-fetch sequencer. It drives the PC register input and write
//   enable, the IF/ID write/flush controls and the instruction memory fetch
//   request. It handles memory wait states, load-use stalls and branch/jump
//   redirects, including a redirect that arrives while a fetch is still
//   outstanding.
//
// Ports
//   clk_i            clock, rising edge
//   rst_i            asynchronous reset, active low
//   start_i          run enable (0 = stop after the current fetch)
//   stall_i          load-use hazard: hold PC and IF/ID
//   branch_i         taken-branch pulse, with branch_target_i
//   jump_i           jump pulse, with jump_target_i (wins over branch_i)
//   pc_i             current PC register value
//   imem_ready_i     instruction memory returns a word this cycle
//   imem_req_o       fetch request
//   pc_next_o        PC register input
//   pc_write_o       PC register write enable
//   ifid_write_o     IF/ID write enable
//   ifid_flush_o     IF/ID flush (bubble)
//   state_o          0 IDLE, 1 FETCH, 2 WAIT, 3 DRAIN
//
// Optional feature (macro PC_SEQ_PERF_CNT_EN)
//   stall_cnt_o      cycles with stall_i=1 in FETCH/WAIT, saturating
//   redirect_cnt_o   accepted redirects, saturating
// ---------------------------------------------------------------------------
module pc_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        stall_i,
    input  logic        branch_i,
    input  logic [31:0] branch_target_i,
    input  logic        jump_i,
    input  logic [31:0] jump_target_i,
    input  logic [31:0] pc_i,
    input  logic        imem_ready_i,
    output logic        imem_req_o,
    output logic [31:0] pc_next_o,
    output logic        pc_write_o,
    output logic        ifid_write_o,
    output logic        ifid_flush_o,
`ifdef PC_SEQ_PERF_CNT_EN
    output logic [15:0] stall_cnt_o,
    output logic [15:0] redirect_cnt_o,
`endif
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] redir_q, redir_d;
    logic        stall_cyc;
    logic        redirect_acc;
    logic        redirect;
    logic [31:0] target;

    assign redirect = jump_i | branch_i;
    assign target   = jump_i ? jump_target_i : branch_target_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            redir_q <= '0;
        end else begin
            state_q <= state_d;
            redir_q <= redir_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        redir_d      = redir_q;
        imem_req_o   = 1'b0;
        pc_next_o    = pc_i;
        pc_write_o   = 1'b0;
        ifid_write_o = 1'b0;
        ifid_flush_o = 1'b0;
        stall_cyc    = 1'b0;
        redirect_acc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) state_d = S_FETCH;
            end
            S_FETCH, S_WAIT: begin
                imem_req_o = 1'b1;
                if (stall_i) begin
                    // Redirect pulses are ignored; the hazard unit re-presents
                    // them. A word returned now is dropped and refetched.
                    stall_cyc = 1'b1;
                    if (imem_ready_i) state_d = S_FETCH;
                end else if (redirect) begin
                    redirect_acc = 1'b1;
                    ifid_flush_o = 1'b1;
                    if (imem_ready_i) begin
                        pc_next_o  = target;
                        pc_write_o = 1'b1;
                        state_d    = start_i ? S_FETCH : S_IDLE;
                    end else begin
                        // Fetch still in flight: hold the target until the
                        // stale word has been drained.
                        redir_d = target;
                        state_d = S_DRAIN;
                    end
                end else if (imem_ready_i) begin
                    pc_next_o    = pc_i + 32'd4;
                    pc_write_o   = 1'b1;
                    ifid_write_o = 1'b1;
                    state_d      = start_i ? S_FETCH : S_IDLE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                imem_req_o = 1'b1;
                if (imem_ready_i) begin
                    pc_next_o    = redir_q;
                    pc_write_o   = 1'b1;
                    ifid_flush_o = 1'b1;
                    state_d      = start_i ? S_FETCH : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign state_o = state_q;

`ifdef PC_SEQ_PERF_CNT_EN
    logic [15:0] stall_cnt_q, redirect_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            if (stall_cyc && stall_cnt_q != '1)
                stall_cnt_q <= stall_cnt_q + 16'd1;
            if (redirect_acc && redirect_cnt_q != '1)
                redirect_cnt_q <= redirect_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_o    = stall_cnt_q;
    assign redirect_cnt_o = redirect_cnt_q;
`endif

endmodule
